// File: rtl/bram_uart_loader.sv
// Boot loader: takes a UART byte stream (4-byte little-endian length, then payload)
// and writes it little-endian into byte-enabled BRAM words from address 0 upward.
module bram_uart_loader #(
    parameter  int AddressBitWidth = 16,
    parameter  int DataBitWidth    = 32,
    localparam int ColumnCount     = DataBitWidth / 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [ColumnCount-1:0]     write_enable,
    output logic [AddressBitWidth-1:0] address,
    output logic [DataBitWidth-1:0]    data_out,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int LaneBits = (ColumnCount > 1) ? $clog2(ColumnCount) : 1;
    // Capacity in bytes, held at 33 bits so a full 32-bit length never overflows the compare.
    localparam logic [32:0] Capacity = 33'(ColumnCount) << AddressBitWidth;

    typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [31:0]                r_len;
    logic [31:0]                r_cnt;
    logic [LaneBits-1:0]        r_lane;
    logic [ColumnCount-1:0]     r_fill;
    logic [DataBitWidth-1:0]    r_word;
    logic [AddressBitWidth-1:0] r_word_idx;
    logic                       r_last;

    logic [31:0]                w_len_hdr;
    logic                       w_len_over;
    logic                       w_hdr_byte;
    logic                       w_hdr_end;
    logic                       w_start_load;
    logic                       w_accept;
    logic                       w_is_last;
    logic                       w_issue;
    logic [DataBitWidth-1:0]    w_word_new;
    logic [ColumnCount-1:0]     w_fill_new;

    // Header bytes shift in from the top so byte 0 ends up in bits [7:0].
    assign w_len_hdr    = {rx_data, r_len[31:8]};
    assign w_len_over   = {1'b0, w_len_hdr} > Capacity;
    assign w_hdr_byte   = (r_state == HEADER) && rx_valid;
    assign w_hdr_end    = w_hdr_byte && (r_cnt[1:0] == 2'd3);
    assign w_start_load = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_accept     = (r_state == DATA) && rx_valid && !r_last;
    assign w_is_last    = (32'(r_cnt + 32'd1) == r_len);
    assign w_issue      = w_accept && ((r_lane == LaneBits'(ColumnCount - 1)) || w_is_last);

    genvar gi;
    generate
        for (gi = 0; gi < ColumnCount; gi++) begin : g_lane
            assign w_word_new[gi*8 +: 8] = (r_lane == LaneBits'(gi)) ? rx_data : r_word[gi*8 +: 8];
            assign w_fill_new[gi]        = r_fill[gi] | (r_lane == LaneBits'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = HEADER;
            HEADER:  if (w_hdr_end) w_state_next = ((w_len_hdr == 32'd0) || w_len_over) ? DONE : DATA;
            DATA:    if (r_last) w_state_next = DONE;
            DONE:    if (start) w_state_next = HEADER;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_len        <= '0;
            r_cnt        <= '0;
            r_lane       <= '0;
            r_fill       <= '0;
            r_word       <= '0;
            r_word_idx   <= '0;
            r_last       <= 1'b0;
            write_enable <= '0;
            address      <= '0;
            data_out     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            busy         <= (w_state_next == HEADER) || (w_state_next == DATA);
            done         <= (w_state_next == DONE);
            write_enable <= '0;

            if (w_start_load) begin
                r_len      <= '0;
                r_cnt      <= '0;
                r_lane     <= '0;
                r_fill     <= '0;
                r_word     <= '0;
                r_word_idx <= '0;
                r_last     <= 1'b0;
                address    <= '0;
                error      <= 1'b0;
            end

            if (w_hdr_byte) begin
                r_len <= w_len_hdr;
                r_cnt <= w_hdr_end ? 32'd0 : 32'(r_cnt + 32'd1);
                if (w_hdr_end) error <= w_len_over;
            end

            if (w_accept) begin
                r_cnt <= 32'(r_cnt + 32'd1);
                if (w_is_last) r_last <= 1'b1;
                if (w_issue) begin
                    write_enable <= w_fill_new;
                    data_out     <= w_word_new;
                    address      <= r_word_idx;
                    r_word_idx   <= r_word_idx + 1'b1;
                    r_word       <= '0;
                    r_fill       <= '0;
                    r_lane       <= '0;
                end else begin
                    r_word <= w_word_new;
                    r_fill <= w_fill_new;
                    r_lane <= r_lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/bram_uart_loader.md
Name: bram_uart_loader

Overview:
Boot-time loader that sits directly upstream of the byte-enabled BRAM and drives its write_enable, address and data_in inputs. It consumes a byte stream from the UART receiver: a 4-byte little-endian length header, then the payload. It packs payload bytes little-endian into BRAM words and writes them at consecutive addresses starting at 0. The CPU is held off by busy until done asserts.

Parameters:
AddressBitWidth, 16, BRAM word-address width; capacity is 2**AddressBitWidth words.
DataBitWidth, 32, BRAM word width; must be a multiple of 8.
ColumnCount, DataBitWidth/8, derived; number of byte lanes. Not overridable.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a load when idle
rx_data  input  8  received UART byte
rx_valid  input  1  single-cycle strobe; rx_data is valid this cycle; no backpressure
write_enable  output  ColumnCount  per-byte-lane BRAM write strobe; connects to bram write_enable
address  output  AddressBitWidth  BRAM word address
data_out  output  DataBitWidth  packed word; connects to bram data_in
busy  output  1  high in HEADER and DATA states
done  output  1  high in DONE state
error  output  1  length exceeded capacity; valid while done=1

Behaviour:
- Reset (async assert, sync release): all outputs 0. State IDLE. Byte count, lane index and length register 0.
- All outputs are registered.
- IDLE: start=1 -> HEADER. An rx_valid in the same cycle as start is ignored.
- HEADER: accept 4 bytes; byte k goes to length[8k+7:8k].
  - On the 4th byte, if length==0 -> DONE, error=0.
  - Else if length > 4*ColumnCount... no: if length > ColumnCount * 2**AddressBitWidth -> DONE, error=1, no writes.
  - Otherwise -> DATA.
- DATA: each accepted byte is placed in lane L of the assembly word; L starts at 0 and wraps at ColumnCount.
  - A write is issued when L reaches ColumnCount-1 or the byte is the last of the payload.
  - Write timing: in the cycle after the byte is accepted, write_enable has a bit set for every lane filled in this word, for exactly 1 cycle. address is the current word index. data_out is the assembled word with unfilled lanes at 0.
  - address increments by 1 after each write. It never wraps, because the length check guarantees this.
  - Lane bits clear after each write; write_enable returns to 0 the next cycle.
  - After the last write -> DONE.
- DONE: done=1, busy=0. error holds its value; address and data_out hold their last values; write_enable=0.
  - start=1 -> HEADER; clears done and error, resets address to 0 and lane index to 0.
- start while busy=1 is ignored.
- rx_valid in IDLE or DONE is ignored.
- Internal length and byte counters are 32 bits. The comparison against capacity is done at 33 bits so it cannot overflow.
- Back-to-back rx_valid on consecutive cycles is supported. Throughput is 1 byte/cycle; a write pipelines behind the next byte's acceptance.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A pending write is dropped. No partial write may follow reset release.

Test Plan:
- Full words: start, header 08 00 00 00, bytes 11..18 -> two writes: address 0, data 0x14131211, we 1111; then address 1, data 0x18171615, we 1111. Then done=1, error=0, busy=0.
- Partial tail: header 06 00 00 00, bytes 21..26 -> address 0, data 0x24232221, we 1111; then address 1, data 0x00002625, we 0011; then done=1.
- Zero length: header 00 00 00 00 -> done=1 the cycle after the 4th header byte. write_enable stays 0 throughout.
- Overflow (AddressBitWidth=4, capacity 64 bytes): header 41 00 00 00 -> done=1, error=1, no writes. Exactly 40 00 00 00 with 64 bytes -> 16 writes, last at address 15, error=0.
- Reset mid-stream: after header 08 and 3 payload bytes, pulse rst_n low for 1 cycle -> all outputs 0 immediately. No write after release. Further rx bytes ignored until start.
- Control edges: start pulsed during DATA -> ignored, load completes normally. start in DONE -> done and error cleared, next load writes from address 0. rx_valid coincident with start -> byte not counted.
